// File: rtl/ibmpc_bus_pkg.sv
// ibmpc_bus_pkg: shared encodings for the IBM PC CPU bus slice
// (bus-cycle types and wait-state controller FSM states).
package ibmpc_bus_pkg;

  typedef enum logic [1:0] {
    CYC_MEM  = 2'b00,
    CYC_IO   = 2'b01,
    CYC_INTA = 2'b10,
    CYC_HALT = 2'b11
  } cyc_type_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    EXT  = 3'd2,
    DONE = 3'd3,
    HOLD = 3'd4
  } ws_state_e;

endpackage

// File: rtl/ws_counter.sv
// ws_counter: loadable wait-state down-counter; last flags the final
// programmed wait clock (count == 1).
module ws_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1'b1);

  // Load wins over decrement so a new cycle always starts from its full count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - ONE;
    end else begin
      count <= count;
    end
  end

  assign last = (count == ONE);

endmodule

// File: rtl/wait_state_ctrl.sv
// wait_state_ctrl: drives 8284A RDY1/AEN1 with per-cycle-type wait states,
// io_ch_rdy stretching and DMA hold. Define WAIT_TIMEOUT_EN for the EXT watchdog.
module wait_state_ctrl
  import ibmpc_bus_pkg::*;
#(
  parameter int MEM_WAITS  = 0,
  parameter int IO_WAITS   = 1,
  parameter int INTA_WAITS = 1,
  parameter int CNT_W      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ale,
  input  logic [1:0] cyc_type,
  input  logic       io_ch_rdy,
  input  logic       cyc_end,
  input  logic       hlda,
  output logic       rdy1,
  output logic       aen1_n,
  output logic       wait_active
`ifdef WAIT_TIMEOUT_EN
  ,
  output logic       timeout_err
`endif
);

  // Reject parameter sets the counter or watchdog cannot represent.
  if (MEM_WAITS >= (32'd1 << CNT_W) || IO_WAITS >= (32'd1 << CNT_W) ||
      INTA_WAITS >= (32'd1 << CNT_W) || TIMEOUT < 32'sd1 || TIMEOUT > 32'sd255) begin : g_bad_cfg
    $error("wait_state_ctrl: wait counts or TIMEOUT out of range");
  end

  ws_state_e        state_r;
  logic             load_s;
  logic             dec_s;
  logic             cnt_last_s;
  logic [CNT_W-1:0] load_val_s;
  logic [CNT_W-1:0] cnt_s;

`ifdef WAIT_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
  logic [7:0] wd_r;
`endif

  function automatic logic [CNT_W-1:0] waits_for(input logic [1:0] t);
    case (t)
      CYC_MEM:  waits_for = CNT_W'(MEM_WAITS);
      CYC_IO:   waits_for = CNT_W'(IO_WAITS);
      CYC_INTA: waits_for = CNT_W'(INTA_WAITS);
      default:  waits_for = '0;
    endcase
  endfunction

  // A new bus cycle is accepted only from IDLE, never for halt, and never against hlda.
  always_comb begin
    load_s     = 1'b0;
    load_val_s = waits_for(cyc_type);
    if (state_r == IDLE && ale && !hlda && cyc_type != CYC_HALT) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
  end

  assign dec_s = (state_r == WAIT) && (cnt_s != '0);

  ws_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .load_val(load_val_s),
    .dec     (dec_s),
    .count   (cnt_s),
    .last    (cnt_last_s)
  );

  // Bus-cycle FSM; outputs are registered one edge behind the state they reflect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      rdy1        <= 1'b1;
      aen1_n      <= 1'b0;
      wait_active <= 1'b0;
`ifdef WAIT_TIMEOUT_EN
      timeout_err <= 1'b0;
      wd_r        <= 8'd0;
`endif
    end else begin
`ifdef WAIT_TIMEOUT_EN
      timeout_err <= 1'b0;
      if (state_r != EXT) wd_r <= 8'd0;
`endif
      case (state_r)
        IDLE: begin
          rdy1        <= 1'b1;
          aen1_n      <= 1'b0;
          wait_active <= 1'b0;
          if (hlda) state_r <= HOLD;
          else if (load_s) state_r <= (load_val_s != '0) ? WAIT : EXT;
          else state_r <= IDLE;
        end
        WAIT: begin
          rdy1        <= 1'b0;
          aen1_n      <= 1'b0;
          wait_active <= 1'b1;
          if (cnt_last_s || cnt_s == '0) state_r <= EXT;
          else state_r <= WAIT;
        end
        EXT: begin
          aen1_n <= 1'b0;
          if (io_ch_rdy) begin
            state_r     <= DONE;
            rdy1        <= 1'b1;
            wait_active <= 1'b0;
          end
`ifdef WAIT_TIMEOUT_EN
          else if (wd_r + 8'd1 == TIMEOUT_W) begin
            state_r     <= DONE;
            rdy1        <= 1'b1;
            wait_active <= 1'b0;
            timeout_err <= 1'b1;
          end
`endif
          else begin
            state_r     <= EXT;
            rdy1        <= 1'b0;
            wait_active <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
            wd_r        <= wd_r + 8'd1;
`endif
          end
        end
        DONE: begin
          rdy1        <= 1'b1;
          aen1_n      <= 1'b0;
          wait_active <= 1'b0;
          if (cyc_end) state_r <= IDLE;
          else state_r <= DONE;
        end
        HOLD: begin
          rdy1        <= 1'b1;
          aen1_n      <= 1'b1;
          wait_active <= 1'b0;
          if (!hlda) state_r <= IDLE;
          else state_r <= HOLD;
        end
        default: begin
          state_r     <= IDLE;
          rdy1        <= 1'b1;
          aen1_n      <= 1'b0;
          wait_active <= 1'b0;
        end
      endcase
    end
  end

endmodule
